// File: rtl/ip_rcv.sv
// IPv4 receive filter: validates the header of each incoming packet and forwards the
// UDP segment payload of accepted packets one word per cycle, dropping everything else.
module ip_rcv #(
    parameter logic [31:0] LOCAL_IP = 32'hC0A80002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ip_valid,
    input  logic [31:0] ip_data,
    input  logic        ip_last,
    output logic        udp_valid,
    output logic [31:0] udp_data,
    output logic [31:0] src_ip,
    output logic        pkt_ok,
    output logic        pkt_drop,
    output logic [15:0] drop_cnt
);

    localparam logic [1:0] HDR     = 2'd0;
    localparam logic [1:0] PAYLOAD = 2'd1;
    localparam logic [1:0] DROP    = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [20:0] csum_q, csum_d;
    logic [3:0]  ihl_q, ihl_d;
    logic [15:0] tlen_q, tlen_d;
    logic        frag_bad_q, frag_bad_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic        dst_ok_q, dst_ok_d;
    logic [15:0] pay_q, pay_d;
    logic        udp_valid_q, udp_valid_d;
    logic [31:0] udp_data_q, udp_data_d;
    logic [31:0] src_ip_q, src_ip_d;
    logic        ok_pend_q, ok_pend_d;
    logic        pkt_ok_q, pkt_ok_d;
    logic        pkt_drop_q, pkt_drop_d;
    logic [15:0] drop_cnt_q;
    logic        drop_inc;

    logic [20:0] sum_next;
    logic [16:0] fold1;
    logic [15:0] fold2;
    logic [3:0]  ihl_cur;
    logic        hdr_end;
    logic        early_bad;
    logic        dst_ok_now;
    logic        accept;
    logic [15:0] pay_len;
    logic [15:0] pay_new;

    always_comb begin
        sum_next   = csum_q + {5'd0, ip_data[31:16]} + {5'd0, ip_data[15:0]};
        fold1      = {1'b0, sum_next[15:0]} + {12'd0, sum_next[20:16]};
        fold2      = fold1[15:0] + {15'd0, fold1[16]};
        // On word0 the header length is only visible on the bus, not yet in ihl_q.
        ihl_cur    = (wcnt_q == 4'd0) ? ip_data[27:24] : ihl_q;
        hdr_end    = (wcnt_q == ihl_cur - 4'd1);
        early_bad  = (wcnt_q == 4'd0) && ((ip_data[31:28] != 4'd4) || (ip_data[27:24] < 4'd5));
        dst_ok_now = (wcnt_q == 4'd4)
                   ? ((ip_data == LOCAL_IP) || (ip_data == 32'hFFFFFFFF)) : dst_ok_q;
        accept     = hdr_end && (fold2 == 16'hFFFF) && dst_ok_now && !frag_bad_q
                   && (tlen_q >= {10'd0, ihl_q, 2'b00}) && (proto_q == 8'd17);
        pay_len    = tlen_q - {10'd0, ihl_q, 2'b00};
        pay_new    = (pay_len + 16'd3) >> 2;
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        csum_d      = csum_q;
        ihl_d       = ihl_q;
        tlen_d      = tlen_q;
        frag_bad_d  = frag_bad_q;
        proto_d     = proto_q;
        src_d       = src_q;
        dst_ok_d    = dst_ok_q;
        pay_d       = pay_q;
        udp_valid_d = 1'b0;
        udp_data_d  = udp_data_q;
        src_ip_d    = src_ip_q;
        ok_pend_d   = 1'b0;
        pkt_ok_d    = ok_pend_q;
        pkt_drop_d  = 1'b0;
        drop_inc    = 1'b0;

        if (ip_valid) begin
            case (state_q)
                HDR: begin
                    csum_d = sum_next;
                    wcnt_d = wcnt_q + 4'd1;
                    case (wcnt_q)
                        4'd0: begin
                            ihl_d  = ip_data[27:24];
                            tlen_d = ip_data[15:0];
                        end
                        4'd1: frag_bad_d = ip_data[13] || (ip_data[12:0] != 13'd0);
                        4'd2: proto_d = ip_data[23:16];
                        4'd3: src_d = ip_data;
                        4'd4: dst_ok_d = dst_ok_now;
                        default: ;
                    endcase
                    if (early_bad || (hdr_end && !accept)) begin
                        pkt_drop_d = 1'b1;
                        drop_inc   = 1'b1;
                        wcnt_d     = 4'd0;
                        csum_d     = '0;
                        state_d    = ip_last ? HDR : DROP;
                    end else if (hdr_end) begin
                        src_ip_d = src_q;
                        pay_d    = pay_new;
                        wcnt_d   = 4'd0;
                        csum_d   = '0;
                        if (pay_new == 16'd0) begin
                            pkt_ok_d = 1'b1;
                            state_d  = ip_last ? HDR : DROP;
                        end else if (ip_last) begin
                            pkt_drop_d = 1'b1;
                            drop_inc   = 1'b1;
                            state_d    = HDR;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else if (ip_last) begin
                        pkt_drop_d = 1'b1;
                        drop_inc   = 1'b1;
                        wcnt_d     = 4'd0;
                        csum_d     = '0;
                    end
                end
                PAYLOAD: begin
                    udp_valid_d = 1'b1;
                    udp_data_d  = ip_data;
                    pay_d       = pay_q - 16'd1;
                    if (pay_q == 16'd1) begin
                        ok_pend_d = 1'b1;
                        state_d   = ip_last ? HDR : DROP;
                    end else if (ip_last) begin
                        pkt_drop_d = 1'b1;
                        drop_inc   = 1'b1;
                        state_d    = HDR;
                    end
                end
                DROP: begin
                    if (ip_last) state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HDR;
            wcnt_q      <= '0;
            csum_q      <= '0;
            ihl_q       <= '0;
            tlen_q      <= '0;
            frag_bad_q  <= 1'b0;
            proto_q     <= '0;
            src_q       <= '0;
            dst_ok_q    <= 1'b0;
            pay_q       <= '0;
            udp_valid_q <= 1'b0;
            udp_data_q  <= '0;
            src_ip_q    <= '0;
            ok_pend_q   <= 1'b0;
            pkt_ok_q    <= 1'b0;
            pkt_drop_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            csum_q      <= csum_d;
            ihl_q       <= ihl_d;
            tlen_q      <= tlen_d;
            frag_bad_q  <= frag_bad_d;
            proto_q     <= proto_d;
            src_q       <= src_d;
            dst_ok_q    <= dst_ok_d;
            pay_q       <= pay_d;
            udp_valid_q <= udp_valid_d;
            udp_data_q  <= udp_data_d;
            src_ip_q    <= src_ip_d;
            ok_pend_q   <= ok_pend_d;
            pkt_ok_q    <= pkt_ok_d;
            pkt_drop_q  <= pkt_drop_d;
            if (drop_inc && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign udp_valid = udp_valid_q;
    assign udp_data  = udp_data_q;
    assign src_ip    = src_ip_q;
    assign pkt_ok    = pkt_ok_q;
    assign pkt_drop  = pkt_drop_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: doc/ip_rcv.md
IP_RCV -- requirements
Module: ip_rcv

Interface
REQ-001 SHALL have parameter LOCAL_IP, default 32'hC0A80002, the IPv4 address accepted as destination.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port ip_valid, input, 1, ip_data carries one IPv4 packet word this cycle; gaps allowed.
REQ-005 SHALL have port ip_data, input, 32, packet word, big-endian (first header byte in [31:24]).
REQ-006 SHALL have port ip_last, input, 1, qualified by ip_valid, final word of the frame (may include L2 padding).
REQ-007 SHALL have port udp_valid, output, 1, udp_data holds one UDP segment word (feeds udp_rcv).
REQ-008 SHALL have port udp_data, output, 32, UDP segment word.
REQ-009 SHALL have port src_ip, output, 32, source address of the packet currently or last forwarded.
REQ-010 SHALL have port pkt_ok, output, 1, one-cycle pulse after the last forwarded word.
REQ-011 SHALL have port pkt_drop, output, 1, one-cycle pulse when a packet is rejected.
REQ-012 SHALL have port drop_cnt, output, 16, count of rejected packets, saturating at 16'hFFFF.

Function
REQ-013 SHALL implement states HDR, PAYLOAD, DROP; word counter wcnt (4 bits) counts accepted words within HDR.
REQ-014 SHALL in HDR capture: word0 version[31:28], ihl[27:24], total_length[15:0]; word1 MF [13], frag_offset [12:0]; word2 protocol[23:16]; word3 src; word4 dst; words 5..ihl-1 are options, parsed only for checksum.
REQ-015 SHALL accumulate a ones-complement sum of both 16-bit halves of every header word (ihl words) in a wide accumulator, folding carries at header end; header valid only if folded sum equals 16'hFFFF.
REQ-016 SHALL accept a header only if version==4, ihl>=5, total_length>=4*ihl, MF==0, frag_offset==0, protocol==8'd17, dst==LOCAL_IP or 32'hFFFFFFFF, and checksum valid.
REQ-017 SHALL evaluate acceptance on the word numbered ihl-1; if ihl<5 or version!=4, SHALL reject on word0.
REQ-018 SHALL on acceptance load pay_words = ceil((total_length - 4*ihl)/4) (16-bit arithmetic), latch src into src_ip, go to PAYLOAD; if pay_words==0, SHALL pulse pkt_ok and go to DROP (discard to ip_last) or HDR if that word was ip_last.
REQ-019 SHALL in PAYLOAD register each ip_valid word to udp_data with udp_valid high exactly 1 cycle later, decrementing pay_words; udp_valid SHALL be low every other cycle.
REQ-020 SHALL after forwarding the last payload word pulse pkt_ok the next cycle, then discard remaining words (padding) in DROP until ip_last, then return to HDR.
REQ-021 SHALL on rejection pulse pkt_drop the next cycle, increment drop_cnt (saturating), go to DROP, or directly to HDR if the rejecting word had ip_last.
REQ-022 SHALL treat ip_last before the header completes, or before pay_words reaches 0, as truncation: pkt_drop pulse, drop_cnt increment, return to HDR; already-forwarded words are not recalled.
REQ-023 SHALL keep pkt_ok and pkt_drop mutually exclusive per packet; ip_last on the last payload word SHALL give pkt_ok and return to HDR.
REQ-024 SHALL hold all state when ip_valid is low (no timeout).
REQ-025 SHALL ignore ip_last when ip_valid is low.

Reset
REQ-026 SHALL on reset low immediately force state HDR, wcnt 0, checksum accumulator 0, udp_valid 0, udp_data 0, src_ip 0, pkt_ok 0, pkt_drop 0, drop_cnt 0.
REQ-027 SHALL after reset release treat the next ip_valid word as header word0; reset mid-packet discards the partial packet without pkt_drop.

Verification
REQ-028 SHALL verify: valid packet ihl=5, total_length=36, proto 17, dst LOCAL_IP, correct checksum, 4 payload words -> udp_valid for words 5..8, each 1 cycle after input, pkt_ok once, src_ip latched.
REQ-029 SHALL verify: same packet with checksum byte flipped -> no udp_valid, pkt_drop once, drop_cnt 0->1.
REQ-030 SHALL verify: ihl=6 with one option word, total_length=30 -> 2 payload words forwarded (ceil 6/4), 2 padding words before ip_last discarded.
REQ-031 SHALL verify: protocol 6 (TCP); dst 10.0.0.9; MF=1 -> each dropped, drop_cnt increments by 3; broadcast dst 255.255.255.255 accepted.
REQ-032 SHALL verify: ip_last on payload word 2 of 4 -> 2 words forwarded, pkt_drop pulse, next packet parsed correctly; drop_cnt preset path to 16'hFFFF stays saturated.
REQ-033 SHALL verify: reset asserted mid-payload with ip_valid gaps -> outputs 0 asynchronously, next packet after release forwarded intact.
